// File: rtl/mem_pkg.sv
// Shared types and sizes for the core-store access arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package mem_pkg;

    localparam int ADDR_W  = 12;  // store decodes addr[10:0]; bit 11 flags out-of-range
    localparam int DATA_W  = 31;  // sign + 30-bit word
    localparam int TIMEOUT = 15;  // WAIT cycles allowed before giving up
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ERR   = 2'd3
    } state_t;

    // Encoding order doubles as the fixed priority order (0 = highest).
    typedef enum logic [1:0] {
        G_IO_WR  = 2'd0,
        G_PNL_WR = 2'd1,
        G_PNL_RD = 2'd2,
        G_PU_RD  = 2'd3
    } grant_t;

    function automatic logic is_write(grant_t g);
        return (g == G_IO_WR) || (g == G_PNL_WR);
    endfunction

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Bundle of requester, store and ack signals around the access arbiter.
// Latency: none (wiring only).
// Backpressure: requests are levels held until the owner sees ack or err.
interface mem_access_arbiter_if;
    import mem_pkg::*;

    logic              io_wr_req;
    logic [ADDR_W-1:0] io_addr;
    logic [DATA_W-1:0] io_wdata;
    logic              pnl_wr_req;
    logic              pnl_rd_req;
    logic [ADDR_W-1:0] pnl_addr;
    logic [DATA_W-1:0] pnl_wdata;
    logic              pu_rd_req;
    logic [ADDR_W-1:0] pu_addr;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_reply;

    logic              io_ack;
    logic              pnl_ack;
    logic              pu_ack;
    logic              err;
    logic              busy;

    // Arbiter side.
    modport slave (
        input  io_wr_req, io_addr, io_wdata,
        input  pnl_wr_req, pnl_rd_req, pnl_addr, pnl_wdata,
        input  pu_rd_req, pu_addr,
        input  mem_reply,
        output mem_read, mem_write, mem_addr, mem_wdata,
        output io_ack, pnl_ack, pu_ack, err, busy
    );

    // Requesters plus store side.
    modport master (
        output io_wr_req, io_addr, io_wdata,
        output pnl_wr_req, pnl_rd_req, pnl_addr, pnl_wdata,
        output pu_rd_req, pu_addr,
        output mem_reply,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        input  io_ack, pnl_ack, pu_ack, err, busy
    );

endinterface

// File: rtl/mem_prio_enc.sv
// Four-input fixed-priority encoder: bit 0 wins, bit 3 loses.
// Latency: combinational.
// Backpressure: none; caller decides when the result is sampled.
module mem_prio_enc
    import mem_pkg::*;
(
    input  logic [3:0] req,
    output grant_t     grant,
    output logic       valid
);

    // Lowest set bit becomes the grant; valid flags any request at all.
    always_comb begin
        grant = G_PU_RD;
        valid = |req;
        if (req[0])      grant = G_IO_WR;
        else if (req[1]) grant = G_PNL_WR;
        else if (req[2]) grant = G_PNL_RD;
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Single-port front end to the core store: arbitrate, strobe once, await reply.
// Latency: strobe 1 cycle after request seen in IDLE; ack same cycle as reply.
// Backpressure: requests outside IDLE are ignored; levels hold them until IDLE.
module mem_access_arbiter
    import mem_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    mem_access_arbiter_if.slave  bus
);

    state_t            state, state_nxt;
    grant_t            grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt;

    grant_t            pick_grant;
    logic              pick_vld;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] pick_wdata;

    logic              latch_en;
    logic              cnt_clr;
    logic              cnt_inc;
    logic              rd_stb;
    logic              wr_stb;
    logic              ack_c;
    logic              err_c;

    // Panel wr and rd both high resolves to write through bit ordering.
    mem_prio_enc u_prio (
        .req   ({bus.pu_rd_req, bus.pnl_rd_req, bus.pnl_wr_req, bus.io_wr_req}),
        .grant (pick_grant),
        .valid (pick_vld)
    );

    // Steer the winning requester's address and write word; reads carry zero.
    always_comb begin
        pick_addr  = bus.pu_addr;
        pick_wdata = '0;
        case (pick_grant)
            G_IO_WR: begin
                pick_addr  = bus.io_addr;
                pick_wdata = bus.io_wdata;
            end
            G_PNL_WR: begin
                pick_addr  = bus.pnl_addr;
                pick_wdata = bus.pnl_wdata;
            end
            G_PNL_RD: pick_addr = bus.pnl_addr;
            default:  pick_addr = bus.pu_addr;
        endcase
    end

    // Next state plus strobe/ack/err decode; ack rides the reply combinationally.
    always_comb begin
        state_nxt = state;
        latch_en  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        rd_stb    = 1'b0;
        wr_stb    = 1'b0;
        ack_c     = 1'b0;
        err_c     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    latch_en  = 1'b1;
                    // Out-of-range address never reaches the store.
                    state_nxt = pick_addr[ADDR_W-1] ? ERR : ISSUE;
                end
            end
            ISSUE: begin
                wr_stb    = is_write(grant_q);
                rd_stb    = !is_write(grant_q);
                cnt_clr   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.mem_reply) begin
                    ack_c     = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_nxt = ERR;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ERR: begin
                err_c     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, latched access and WAIT counter; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grant_q <= G_IO_WR;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= '0;
        end else begin
            state <= state_nxt;
            if (latch_en) begin
                grant_q <= pick_grant;
                addr_q  <= pick_addr;
                wdata_q <= pick_wdata;
            end
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;
        end
    end

    assign bus.mem_read  = rd_stb;
    assign bus.mem_write = wr_stb;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.io_ack    = ack_c && (grant_q == G_IO_WR);
    assign bus.pnl_ack   = ack_c && ((grant_q == G_PNL_WR) || (grant_q == G_PNL_RD));
    assign bus.pu_ack    = ack_c && (grant_q == G_PU_RD);
    assign bus.err       = err_c;
    assign bus.busy      = (state != IDLE);

endmodule
